tp_probe_conditioner: RTL and testbench

//  Conditions internal debug probes before they reach the test-point IOBUF stage.

---
 rtl/tp_probe_conditioner.sv | 151 +++++++++++++++
 tb/tb_tp_probe_conditioner.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tp_probe_conditioner.sv
// tp_probe_conditioner
// Conditions two 16-bit debug probe groups for the test-point output stage.
// Each group is synchronised and edge-detected. Single-cycle pulses are stretched so a
// scope can see them. One group/mode is driven onto TP_OUT. Rising edges of one selectable
// probe bit are counted between SNAP strobes.
module tp_probe_conditioner #(
  parameter int STRETCH = 8,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [15:0]      PROBE_A,
  input  logic [15:0]      PROBE_B,
  input  logic             SEL_REQ,
  input  logic [1:0]       SEL_VAL,
  input  logic [3:0]       CNT_SEL,
  input  logic             SNAP,
  output logic [15:0]      TP_OUT,
  output logic [1:0]       SEL_ACT,
  output logic [CNT_W-1:0] EVT_CNT,
  output logic             CNT_OVF
);

  // Wide enough to hold STRETCH-1. The edge cycle itself supplies the first high cycle.
  localparam int SW = (STRETCH > 1) ? $clog2(STRETCH) : 1;
  localparam logic [SW-1:0]    STR_LOAD = SW'(STRETCH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [15:0] s1_a, s2_a, s3_a;
  logic [15:0] s1_b, s2_b, s3_b;
  logic [15:0] edge_a, edge_b;
  logic [15:0] str_a, str_b;
  logic [SW-1:0] cnt_a [16];
  logic [SW-1:0] cnt_b [16];
  logic [15:0] mux_out;
  logic        cnt_edge;
  logic [CNT_W-1:0] edge_cnt, edge_cnt_next;
  logic        ovf, ovf_next;

  // Two-flop synchroniser plus a previous-sample flop per group for edge detection
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_a <= '0;
      s2_a <= '0;
      s3_a <= '0;
      s1_b <= '0;
      s2_b <= '0;
      s3_b <= '0;
    end else begin
      s1_a <= PROBE_A;
      s2_a <= s1_a;
      s3_a <= s2_a;
      s1_b <= PROBE_B;
      s2_b <= s1_b;
      s3_b <= s2_b;
    end
  end

  assign edge_a = s2_a & ~s3_a;
  assign edge_b = s2_b & ~s3_b;

  // Per-bit stretch counters: reload on every rising edge, otherwise run down to zero
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) begin
        cnt_a[i] <= '0;
        cnt_b[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (edge_a[i]) begin
          cnt_a[i] <= STR_LOAD;
        end else if (cnt_a[i] != '0) begin
          cnt_a[i] <= cnt_a[i] - 1'b1;
        end
        if (edge_b[i]) begin
          cnt_b[i] <= STR_LOAD;
        end else if (cnt_b[i] != '0) begin
          cnt_b[i] <= cnt_b[i] - 1'b1;
        end
      end
    end
  end

  // Stretched bit is high on the edge cycle itself and while the counter is still running
  always_comb begin
    str_a = '0;
    str_b = '0;
    for (int i = 0; i < 16; i++) begin
      str_a[i] = edge_a[i] | (cnt_a[i] != '0);
      str_b[i] = edge_b[i] | (cnt_b[i] != '0);
    end
  end

  // Output source select for the currently applied mode
  always_comb begin
    mux_out = '0;
    case (SEL_ACT)
      2'd0:    mux_out = s2_a;
      2'd1:    mux_out = str_a;
      2'd2:    mux_out = s2_b;
      default: mux_out = str_b;
    endcase
  end

  // Mode register and output register; a real mode change blanks TP_OUT for one cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SEL_ACT <= '0;
      TP_OUT  <= '0;
    end else begin
      if (SEL_REQ) begin
        SEL_ACT <= SEL_VAL;
      end
      if (SEL_REQ && (SEL_VAL != SEL_ACT)) begin
        TP_OUT <= '0;
      end else begin
        TP_OUT <= mux_out;
      end
    end
  end

  // Next counter value including this cycle's raw edge, saturating at all-ones
  always_comb begin
    cnt_edge      = SEL_ACT[1] ? edge_b[CNT_SEL] : edge_a[CNT_SEL];
    edge_cnt_next = edge_cnt;
    if (cnt_edge && (edge_cnt != CNT_MAX)) begin
      edge_cnt_next = edge_cnt + CNT_W'(1);
    end
    ovf_next = ovf | (cnt_edge && (edge_cnt_next == CNT_MAX));
  end

  // Edge counter with snapshot: SNAP captures the count (with a same-cycle edge) and clears it
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt <= '0;
      ovf      <= 1'b0;
      EVT_CNT  <= '0;
      CNT_OVF  <= 1'b0;
    end else if (SNAP) begin
      EVT_CNT  <= edge_cnt_next;
      CNT_OVF  <= ovf_next;
      edge_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      edge_cnt <= edge_cnt_next;
      ovf      <= ovf_next;
    end
  end

endmodule

// File: tb/tb_tp_probe_conditioner.sv
// Testbench for tp_probe_conditioner.
// A sliding-window model over the history of sampled probe values predicts every output;
// a 16-bit and a 4-bit counter instance share the same stimulus.
module tb_tp_probe_conditioner;
  localparam int STRETCH = 8;
  localparam int HD      = 12;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] probe_a = '0;
  logic [15:0] probe_b = '0;
  logic        sel_req = 1'b0;
  logic [1:0]  sel_val = '0;
  logic [3:0]  cnt_sel = '0;
  logic        snap = 1'b0;

  logic [15:0] tp_out, tp_out_s;
  logic [1:0]  sel_act, sel_act_s;
  logic [15:0] evt_cnt;
  logic [3:0]  evt_cnt_s;
  logic        cnt_ovf, cnt_ovf_s;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  tp_probe_conditioner #(.STRETCH(STRETCH), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .PROBE_A(probe_a), .PROBE_B(probe_b),
    .SEL_REQ(sel_req), .SEL_VAL(sel_val), .CNT_SEL(cnt_sel), .SNAP(snap),
    .TP_OUT(tp_out), .SEL_ACT(sel_act), .EVT_CNT(evt_cnt), .CNT_OVF(cnt_ovf)
  );

  tp_probe_conditioner #(.STRETCH(STRETCH), .CNT_W(4)) dut_small (
    .CLK(CLK), .RST(RST), .PROBE_A(probe_a), .PROBE_B(probe_b),
    .SEL_REQ(sel_req), .SEL_VAL(sel_val), .CNT_SEL(cnt_sel), .SNAP(snap),
    .TP_OUT(tp_out_s), .SEL_ACT(sel_act_s), .EVT_CNT(evt_cnt_s), .CNT_OVF(cnt_ovf_s)
  );

  always #5 CLK = ~CLK;

  // Model state: ha[k]/hb[k] is the probe value sampled k+1 clock edges ago
  logic [15:0] ha [HD];
  logic [15:0] hb [HD];
  logic [1:0]  m_mode;
  logic [15:0] m_tp;
  int          m_cnt16, m_cnt4, m_evt16, m_evt4;
  bit          m_ovf16, m_ovf4, m_covf16, m_covf4;

  // Stretched view: bit high if it rose within the last STRETCH samples reaching the output
  function automatic logic [15:0] win(input bit grp);
    logic [15:0] r;
    r = '0;
    for (int k = 1; k <= STRETCH; k++) begin
      r |= grp ? (hb[k] & ~hb[k+1]) : (ha[k] & ~ha[k+1]);
    end
    return r;
  endfunction

  function automatic logic [15:0] mode_data(input logic [1:0] m);
    case (m)
      2'd0:    return ha[1];
      2'd1:    return win(1'b0);
      2'd2:    return hb[1];
      default: return win(1'b1);
    endcase
  endfunction

  function automatic bit cnt_edge();
    return m_mode[1] ? (hb[1][cnt_sel] & ~hb[2][cnt_sel]) : (ha[1][cnt_sel] & ~ha[2][cnt_sel]);
  endfunction

  function automatic int sat_next(input int c, input bit e, input int mx);
    return (e && c < mx) ? c + 1 : c;
  endfunction

  function automatic bit ovf_next(input bit o, input int c, input bit e, input int mx);
    return o || (e && sat_next(c, e, mx) == mx);
  endfunction

  // Reference model advanced on every clock edge
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < HD; k++) begin
        ha[k] <= '0;
        hb[k] <= '0;
      end
      m_mode <= '0; m_tp <= '0;
      m_cnt16 <= 0; m_cnt4 <= 0; m_evt16 <= 0; m_evt4 <= 0;
      m_ovf16 <= 1'b0; m_ovf4 <= 1'b0; m_covf16 <= 1'b0; m_covf4 <= 1'b0;
    end else begin
      m_tp <= (sel_req && sel_val != m_mode) ? 16'h0000 : mode_data(m_mode);
      if (sel_req) m_mode <= sel_val;
      if (snap) begin
        m_evt16  <= sat_next(m_cnt16, cnt_edge(), 65535);
        m_covf16 <= ovf_next(m_ovf16, m_cnt16, cnt_edge(), 65535);
        m_evt4   <= sat_next(m_cnt4, cnt_edge(), 15);
        m_covf4  <= ovf_next(m_ovf4, m_cnt4, cnt_edge(), 15);
        m_cnt16 <= 0; m_ovf16 <= 1'b0; m_cnt4 <= 0; m_ovf4 <= 1'b0;
      end else begin
        m_cnt16 <= sat_next(m_cnt16, cnt_edge(), 65535);
        m_ovf16 <= ovf_next(m_ovf16, m_cnt16, cnt_edge(), 65535);
        m_cnt4  <= sat_next(m_cnt4, cnt_edge(), 15);
        m_ovf4  <= ovf_next(m_ovf4, m_cnt4, cnt_edge(), 15);
      end
      ha[0] <= probe_a;
      hb[0] <= probe_b;
      for (int k = 1; k < HD; k++) begin
        ha[k] <= ha[k-1];
        hb[k] <= hb[k-1];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle compare of both instances against the model
  always @(negedge CLK) begin
    if (check_en) begin
      checkOutput("tp_out", tp_out, m_tp);
      checkOutput("sel_act", sel_act, m_mode);
      checkOutput("evt_cnt", evt_cnt, m_evt16);
      checkOutput("cnt_ovf", cnt_ovf, m_covf16);
      checkOutput("tp_out_s", tp_out_s, m_tp);
      checkOutput("evt_cnt_s", evt_cnt_s, m_evt4);
      checkOutput("cnt_ovf_s", cnt_ovf_s, m_covf4);
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    probe_a = a;
    probe_b = b;
    tick();
  endtask

  task automatic selectMode(input logic [1:0] v);
    sel_req = 1'b1;
    sel_val = v;
    tick();
    sel_req = 1'b0;
    repeat (12) tick();
  endtask

  task automatic doSnap();
    snap = 1'b1;
    tick();
    snap = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_tp"}, tp_out, 0);
    checkOutput({tag, "_sel"}, sel_act, 0);
    checkOutput({tag, "_evt"}, evt_cnt, 0);
    checkOutput({tag, "_ovf"}, cnt_ovf, 0);
    checkOutput({tag, "_evt_s"}, evt_cnt_s, 0);
  endtask

  initial begin
    int hi;
    int rises;
    logic prev;

    repeat (3) tick();
    checkAllZero("reset");
    RST = 1'b0;
    check_en = 1'b1;
    tick();

    // T1: raw mode 0, one-cycle pulse appears 3 cycles later for one cycle
    applyStimulus(16'h0001, 16'h0000);
    checkOutput("t1_c1", tp_out, 16'h0000);
    applyStimulus(16'h0000, 16'h0000);
    checkOutput("t1_c2", tp_out, 16'h0000);
    tick();
    checkOutput("t1_c3", tp_out, 16'h0001);
    tick();
    checkOutput("t1_c4", tp_out, 16'h0000);

    // T2: stretched mode 1, retriggered pulse on bit 3 gives 13 contiguous high cycles
    selectMode(2'd1);
    hi = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (tp_out[3] && !prev) rises++;
      if (tp_out[3]) hi++;
      prev = tp_out[3];
      applyStimulus((i == 0 || i == 5) ? 16'h0008 : 16'h0000, 16'h0000);
    end
    checkOutput("t2_high_cycles", hi, 13);
    checkOutput("t2_rises", rises, 1);

    // T3: mode 0 -> 3 with B held high: one blank cycle, no re-stretch, then a new edge
    selectMode(2'd0);
    repeat (15) applyStimulus(16'h00FF, 16'hFFFF);
    checkOutput("t3_mode0", tp_out, 16'h00FF);
    sel_req = 1'b1;
    sel_val = 2'd3;
    tick();
    sel_req = 1'b0;
    checkOutput("t3_blank", tp_out, 16'h0000);
    checkOutput("t3_sel", sel_act, 2'd3);
    tick();
    checkOutput("t3_after_blank", tp_out, 16'h0000);
    repeat (3) tick();
    checkOutput("t3_level", tp_out, 16'h0000);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (tp_out == 16'hFFFF) hi++;
      applyStimulus(16'h00FF, (i == 0) ? 16'h0000 : 16'hFFFF);
    end
    checkOutput("t3_edge_high", hi, 8);

    // T4: 1000 counted pulses on A[5], then a back-to-back SNAP
    selectMode(2'd0);
    cnt_sel = 4'd5;
    repeat (4) applyStimulus(16'h0000, 16'h0000);
    doSnap();
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(16'h0020, 16'h0000);
      applyStimulus(16'h0000, 16'h0000);
    end
    repeat (3) tick();
    doSnap();
    checkOutput("t4_evt", evt_cnt, 1000);
    checkOutput("t4_ovf", cnt_ovf, 0);
    checkOutput("t4_evt_s", evt_cnt_s, 15);
    checkOutput("t4_ovf_s", cnt_ovf_s, 1);
    doSnap();
    checkOutput("t4_evt2", evt_cnt, 0);
    checkOutput("t4_ovf_s2", cnt_ovf_s, 0);

    // T5: 20 pulses saturate the 4-bit counter; a pulse coincident with SNAP is captured
    for (int i = 0; i < 20; i++) begin
      applyStimulus(16'h0020, 16'h0000);
      applyStimulus(16'h0000, 16'h0000);
    end
    repeat (3) tick();
    doSnap();
    checkOutput("t5_evt", evt_cnt, 20);
    checkOutput("t5_evt_s", evt_cnt_s, 15);
    checkOutput("t5_ovf_s", cnt_ovf_s, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h0020, 16'h0000);
      applyStimulus(16'h0000, 16'h0000);
    end
    applyStimulus(16'h0020, 16'h0000);
    applyStimulus(16'h0000, 16'h0000);
    doSnap();
    checkOutput("t5_coinc", evt_cnt, 4);
    checkOutput("t5_coinc_s", evt_cnt_s, 4);
    checkOutput("t5_coinc_ovf_s", cnt_ovf_s, 0);

    // T6: asynchronous reset mid-stretch and mid-count
    selectMode(2'd1);
    applyStimulus(16'h0024, 16'h0000);
    applyStimulus(16'h0000, 16'h0000);
    repeat (3) tick();
    checkOutput("t6_pre_tp", tp_out, 16'h0024);
    #2 RST = 1'b1;
    #1 checkAllZero("t6_async");
    tick();
    RST = 1'b0;
    tick();
    checkAllZero("t6_release");
    applyStimulus(16'h0020, 16'h0000);
    applyStimulus(16'h0000, 16'h0000);
    repeat (3) tick();
    doSnap();
    checkOutput("t6_evt", evt_cnt, 1);
    checkOutput("t6_ovf", cnt_ovf, 0);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
